jstk_frame_reader: RTL and testbench

SPI master and decoder for one joystick module (PmodJSTK-style, 5-byte frame). It polls the joystick on a fixed period, captures 10-bit X/Y and button bits, and converts stick deflection into one-cycle direction pulses with hold-to-repeat. It sits directly upstream of the game top level, driving its cursor/scroll `left/right/up/down` and `click/down_click` inputs; one instance per joystick.

---
 rtl/jstk_pkg.sv | 31 +++
 rtl/jstk_frame_reader_spi_byte_shifter.sv | 88 ++++++++
 rtl/jstk_frame_reader.sv | 250 +++++++++++++++++++++++++
 tb/tb_jstk_frame_reader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jstk_pkg.sv
// Shared types and constants for the joystick frame reader.
// Frame layout indices, button bits, command byte and reset centre.
package jstk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_HOLD,
    ST_DONE
  } jstk_state_e;

  localparam logic [2:0] BYTE_X_LO = 3'd0;
  localparam logic [2:0] BYTE_X_HI = 3'd1;
  localparam logic [2:0] BYTE_Y_LO = 3'd2;
  localparam logic [2:0] BYTE_Y_HI = 3'd3;
  localparam logic [2:0] BYTE_BTN  = 3'd4;

  localparam int BTN_STICK = 0;
  localparam int BTN_1     = 1;

  localparam logic [7:0] CMD_LED_OFF = 8'h80;
  localparam logic [9:0] POS_CENTRE  = 10'd512;

  localparam int DIR_L = 0;
  localparam int DIR_R = 1;
  localparam int DIR_U = 2;
  localparam int DIR_D = 3;

endpackage

// File: rtl/jstk_frame_reader_spi_byte_shifter.sv
// Mode-0 single-byte SPI engine: rise on start, 16 half periods,
// done in the last clk of the trailing low half.
module spi_byte_shifter #(
  parameter int SCLK_HALF = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       busy,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       sclk,
  output logic       mosi
);

  localparam logic [15:0] HLAST = 16'(SCLK_HALF - 1);

  logic       busy_q, busy_d;
  logic       sclk_q, sclk_d;
  logic [3:0] ph_q, ph_d;
  logic [15:0] hc_q, hc_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       half_end;

  assign half_end = busy_q && (hc_q == HLAST);

  always_comb begin
    busy_d = busy_q;
    sclk_d = sclk_q;
    ph_d   = ph_q;
    hc_d   = hc_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    if (start && !busy_q) begin
      busy_d = 1'b1;
      sclk_d = 1'b1;
      ph_d   = 4'd0;
      hc_d   = 16'd0;
      tx_d   = tx_byte;
      rx_d   = {rx_q[6:0], miso};
    end else if (busy_q) begin
      hc_d = hc_q + 16'd1;
      if (half_end) begin
        hc_d = 16'd0;
        ph_d = ph_q + 4'd1;
        if (ph_q == 4'd15) begin
          busy_d = 1'b0;
          sclk_d = 1'b0;
        end else if (!ph_q[0]) begin
          sclk_d = 1'b0;
          tx_d   = {tx_q[6:0], 1'b0};
        end else begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[6:0], miso};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      ph_q   <= 4'd0;
      hc_q   <= 16'd0;
      tx_q   <= 8'd0;
      rx_q   <= 8'd0;
    end else begin
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      ph_q   <= ph_d;
      hc_q   <= hc_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
    end
  end

  // Before the first rise MOSI already presents the MSB of tx_byte.
  assign mosi    = busy_q ? tx_q[7] : tx_byte[7];
  assign busy    = busy_q;
  assign rx_byte = rx_q;
  assign sclk    = sclk_q;
  assign done    = half_end && (ph_q == 4'd15);

endmodule

// File: rtl/jstk_frame_reader.sv
// Joystick poller: 5-byte SPI frame, X/Y capture, threshold
// classification and hold-to-repeat direction pulses.
module jstk_frame_reader
  import jstk_pkg::*;
#(
  parameter int SCLK_HALF    = 50,
  parameter int SS_SETUP     = 1500,
  parameter int BYTE_GAP     = 1000,
  parameter int POLL_CYCLES  = 1_000_000,
  parameter int LOW_TH       = 300,
  parameter int HIGH_TH      = 700,
  parameter int REPEAT_POLLS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       MISO,
  output logic       SS,
  output logic       MOSI,
  output logic       SCLK,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       click,
  output logic       down_click,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       frame_valid
);

  localparam logic [31:0] SU_LAST   = 32'(SS_SETUP - 1);
  localparam logic [31:0] GAP_LAST  = 32'(BYTE_GAP - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);
  localparam logic [9:0]  LO        = 10'(LOW_TH);
  localparam logic [9:0]  HI        = 10'(HIGH_TH);
  localparam logic [5:0]  RP        = 6'(REPEAT_POLLS);

  jstk_state_e state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [31:0] poll_q, poll_d;
  logic [2:0]  byte_q, byte_d;
  logic [7:0]  xl_q, xl_d, yl_q, yl_d, btn_q, btn_d;
  logic [1:0]  xh_q, xh_d, yh_q, yh_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        clk_q, clk_d, dclk_q, dclk_d;
  logic        fv_q, fv_d;
  logic [3:0]  pulse_q, pulse_d;
  logic [3:0]  act_q, act_d;
  logic [3:0][4:0] hc_q, hc_d;

  logic        sh_start, sh_busy, sh_done;
  logic [7:0]  tx_byte, rx_byte;
  logic        commit;
  logic [9:0]  x_new, y_new;
  logic [3:0]  act_now;
  logic [5:0]  nxt;

  spi_byte_shifter #(
    .SCLK_HALF(SCLK_HALF)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .start  (sh_start),
    .tx_byte(tx_byte),
    .miso   (MISO),
    .busy   (sh_busy),
    .rx_byte(rx_byte),
    .done   (sh_done),
    .sclk   (SCLK),
    .mosi   (MOSI)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (poll_q == 32'd0) state_d = ST_SETUP;
      ST_SETUP:
        if (tmr_q == SU_LAST) state_d = ST_SHIFT;
      ST_SHIFT:
        if (sh_done)
          state_d = (byte_q == BYTE_BTN) ? ST_HOLD : ST_GAP;
      ST_GAP:
        if (tmr_q == GAP_LAST) state_d = ST_SHIFT;
      ST_HOLD:
        if (tmr_q == SU_LAST) state_d = ST_DONE;
      ST_DONE:
        state_d = (poll_q == 32'd0) ? ST_SETUP : ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    SS       = 1'b1;
    sh_start = 1'b0;
    tx_byte  = 8'h00;
    commit   = 1'b0;
    unique case (state_q)
      ST_SETUP: begin
        SS       = 1'b0;
        sh_start = (tmr_q == SU_LAST) && !sh_busy;
        tx_byte  = CMD_LED_OFF;
      end
      ST_SHIFT: begin
        SS = 1'b0;
        if (byte_q == BYTE_X_LO) tx_byte = CMD_LED_OFF;
      end
      ST_GAP: begin
        SS       = 1'b0;
        sh_start = (tmr_q == GAP_LAST) && !sh_busy;
      end
      ST_HOLD: begin
        SS     = 1'b0;
        commit = (tmr_q == SU_LAST);
      end
      default: ;
    endcase
  end

  assign x_new = {xh_q, xl_q};
  assign y_new = {yh_q, yl_q};

  always_comb begin
    act_now        = 4'd0;
    act_now[DIR_L] = x_new < LO;
    act_now[DIR_R] = x_new > HI;
    act_now[DIR_U] = y_new > HI;
    act_now[DIR_D] = y_new < LO;
  end

  always_comb begin
    tmr_d  = (state_d != state_q) ? 32'd0 : tmr_q + 32'd1;
    // The poll period is measured SS fall to SS fall.
    if (state_d == ST_SETUP && state_q != ST_SETUP)
      poll_d = POLL_LAST;
    else if (poll_q != 32'd0)
      poll_d = poll_q - 32'd1;
    else
      poll_d = 32'd0;
    byte_d = byte_q;
    if (state_q == ST_IDLE || state_q == ST_DONE)
      byte_d = 3'd0;
    else if (sh_done)
      byte_d = byte_q + 3'd1;
    xl_d  = xl_q;
    xh_d  = xh_q;
    yl_d  = yl_q;
    yh_d  = yh_q;
    btn_d = btn_q;
    if (sh_done) begin
      case (byte_q)
        BYTE_X_LO: xl_d  = rx_byte;
        BYTE_X_HI: xh_d  = rx_byte[1:0];
        BYTE_Y_LO: yl_d  = rx_byte;
        BYTE_Y_HI: yh_d  = rx_byte[1:0];
        BYTE_BTN:  btn_d = rx_byte;
        default: ;
      endcase
    end
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    clk_d   = clk_q;
    dclk_d  = dclk_q;
    fv_d    = commit;
    pulse_d = 4'd0;
    act_d   = act_q;
    hc_d    = hc_q;
    nxt     = 6'd0;
    if (commit) begin
      x_d    = x_new;
      y_d    = y_new;
      clk_d  = btn_q[BTN_STICK];
      dclk_d = btn_q[BTN_1];
      act_d  = act_now;
      for (int i = 0; i < 4; i++) begin
        nxt = {1'b0, hc_q[i]} + 6'd1;
        if (nxt > 6'd31) nxt = 6'd31;
        if (!act_now[i]) begin
          hc_d[i] = 5'd0;
        end else if (!act_q[i]) begin
          pulse_d[i] = 1'b1;
          hc_d[i]    = 5'd0;
        end else if (RP != 6'd0 && nxt == RP) begin
          pulse_d[i] = 1'b1;
          hc_d[i]    = 5'd0;
        end else begin
          hc_d[i] = nxt[4:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q   <= 32'd0;
      poll_q  <= 32'd15;
      byte_q  <= 3'd0;
      xl_q    <= 8'd0;
      xh_q    <= 2'd0;
      yl_q    <= 8'd0;
      yh_q    <= 2'd0;
      btn_q   <= 8'd0;
      x_q     <= POS_CENTRE;
      y_q     <= POS_CENTRE;
      clk_q   <= 1'b0;
      dclk_q  <= 1'b0;
      fv_q    <= 1'b0;
      pulse_q <= 4'd0;
      act_q   <= 4'd0;
      hc_q    <= '0;
    end else begin
      tmr_q   <= tmr_d;
      poll_q  <= poll_d;
      byte_q  <= byte_d;
      xl_q    <= xl_d;
      xh_q    <= xh_d;
      yl_q    <= yl_d;
      yh_q    <= yh_d;
      btn_q   <= btn_d;
      x_q     <= x_d;
      y_q     <= y_d;
      clk_q   <= clk_d;
      dclk_q  <= dclk_d;
      fv_q    <= fv_d;
      pulse_q <= pulse_d;
      act_q   <= act_d;
      hc_q    <= hc_d;
    end
  end

  assign left        = pulse_q[DIR_L];
  assign right       = pulse_q[DIR_R];
  assign up          = pulse_q[DIR_U];
  assign down        = pulse_q[DIR_D];
  assign click       = clk_q;
  assign down_click  = dclk_q;
  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_jstk_frame_reader.sv
// Directed bench: SPI joystick model, two instances (repeat 20 / 0).
// Short timing parameters keep each frame at 189 clk within a 200 clk poll.
module tb_jstk_frame_reader;

  localparam int H  = 2;
  localparam int SU = 6;
  localparam int GP = 4;
  localparam int PC = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic miso;
  always #5 clk = ~clk;

  logic a_ss, a_mosi, a_sclk, a_l, a_r, a_u, a_d;
  logic a_clk, a_dclk, a_fv;
  logic [9:0] a_x, a_y;
  logic b_ss, b_mosi, b_sclk, b_l, b_r, b_u, b_d;
  logic b_clk, b_dclk, b_fv;
  logic [9:0] b_x, b_y;

  jstk_frame_reader #(
    .SCLK_HALF(H), .SS_SETUP(SU), .BYTE_GAP(GP),
    .POLL_CYCLES(PC), .LOW_TH(300), .HIGH_TH(700),
    .REPEAT_POLLS(20)
  ) u_a (
    .clk(clk), .rst(rst), .MISO(miso),
    .SS(a_ss), .MOSI(a_mosi), .SCLK(a_sclk),
    .left(a_l), .right(a_r), .up(a_u), .down(a_d),
    .click(a_clk), .down_click(a_dclk),
    .x_pos(a_x), .y_pos(a_y), .frame_valid(a_fv)
  );

  jstk_frame_reader #(
    .SCLK_HALF(H), .SS_SETUP(SU), .BYTE_GAP(GP),
    .POLL_CYCLES(PC), .LOW_TH(300), .HIGH_TH(700),
    .REPEAT_POLLS(0)
  ) u_b (
    .clk(clk), .rst(rst), .MISO(miso),
    .SS(b_ss), .MOSI(b_mosi), .SCLK(b_sclk),
    .left(b_l), .right(b_r), .up(b_u), .down(b_d),
    .click(b_clk), .down_click(b_dclk),
    .x_pos(b_x), .y_pos(b_y), .frame_valid(b_fv)
  );

  int total = 0;
  int bad   = 0;

  logic [39:0] fbits;
  logic [39:0] mosi_sh;
  int  rcnt = 0;
  time r1_t, r2_t;
  time t0, t1, t2;
  int  a_rc = 0;
  int  b_rc = 0;
  int  stray = 0;

  function automatic logic [39:0] mk(input logic [9:0] x,
                                     input logic [9:0] y,
                                     input logic [7:0] b);
    return {x[7:0], 6'b101101, x[9:8],
            y[7:0], 6'b010011, y[9:8], b};
  endfunction

  always @(negedge a_ss or posedge a_sclk) begin
    if (!a_ss && !a_sclk) begin
      rcnt    = 0;
      mosi_sh = 40'd0;
    end else if (a_sclk) begin
      rcnt++;
      mosi_sh = {mosi_sh[38:0], a_mosi};
      if (rcnt == 1) r1_t = $time;
      if (rcnt == 2) r2_t = $time;
    end
  end

  always_comb begin
    miso = 1'b0;
    if (!a_ss && rcnt < 40) miso = fbits[6'(39 - rcnt)];
  end

  always @(negedge a_ss) begin
    t2 = t1;
    t1 = t0;
    t0 = $time;
  end

  always @(posedge clk) begin
    if (a_r === 1'b1) a_rc++;
    if (b_r === 1'b1) b_rc++;
    if (((a_l | a_r | a_u | a_d) === 1'b1) && a_fv !== 1'b1) stray++;
    if (((b_l | b_r | b_u | b_d) === 1'b1) && b_fv !== 1'b1) stray++;
  end

  task automatic chk(input string tag, input logic [39:0] got,
                     input logic [39:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wait_fv();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (a_fv) begin
        ok = 1'b1;
        break;
      end
    end
    chk("fv_seen", 40'(ok), 40'd1);
  endtask

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] b;
    logic [3:0] dirs;
    logic [1:0] lv;
  } vec_t;

  vec_t vt[6];

  initial begin
    int n;
    int ra0, rb0;
    bit ok, moved;

    vt[0] = '{10'd700, 10'd512, 8'h00, 4'b0000, 2'b00};
    vt[1] = '{10'd701, 10'd300, 8'h02, 4'b0100, 2'b01};
    vt[2] = '{10'd300, 10'd299, 8'h03, 4'b0001, 2'b11};
    vt[3] = '{10'd100, 10'd900, 8'h00, 4'b1010, 2'b00};
    vt[4] = '{10'd299, 10'd701, 8'h01, 4'b0000, 2'b10};
    vt[5] = '{10'd450, 10'd700, 8'h00, 4'b0000, 2'b00};

    fbits = mk(10'h080, 10'h200, 8'h01);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ss", 40'(a_ss), 40'd1);
    chk("rst_sclk", 40'(a_sclk), 40'd0);
    chk("rst_mosi", 40'(a_mosi), 40'd0);
    chk("rst_pos", 40'({a_x, a_y}), 40'({10'd512, 10'd512}));
    chk("rst_lvl", 40'({a_clk, a_dclk, a_fv, a_l, a_r, a_u, a_d}),
        40'd0);

    @(negedge clk) rst = 1'b0;
    n = 0;
    while (a_ss && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("first_ss_fall", 40'(n), 40'd16);

    wait_fv();
    chk("f1_x", 40'(a_x), 40'd128);
    chk("f1_y", 40'(a_y), 40'd512);
    chk("f1_lv", 40'({a_clk, a_dclk}), 40'b10);
    chk("f1_dir_a", 40'({a_l, a_r, a_u, a_d}), 40'b1000);
    chk("f1_dir_b", 40'({b_l, b_r, b_u, b_d, b_fv}), 40'b10001);
    chk("f1_rises", 40'(rcnt), 40'd40);
    chk("f1_mosi", mosi_sh, 40'h80_0000_0000);
    chk("sclk_period", 40'(r2_t - r1_t), 40'(2 * H * 10));

    fbits = mk(10'd1000, 10'd512, 8'h00);
    ra0 = a_rc;
    rb0 = b_rc;
    for (int f = 1; f <= 45; f++) begin
      wait_fv();
      if (f == 1 || f == 21 || f == 41)
        chk($sformatf("rep_f%0d", f), 40'(a_r), 40'd1);
    end
    @(posedge clk);
    #1;
    chk("rep_total_a", 40'(a_rc - ra0), 40'd3);
    chk("rep_total_b", 40'(b_rc - rb0), 40'd1);
    chk("hold_x", 40'(a_x), 40'd1000);
    chk("ss_period1", 40'(t0 - t1), 40'(PC * 10));
    chk("ss_period2", 40'(t1 - t2), 40'(PC * 10));

    for (int v = 0; v < 6; v++) begin
      fbits = mk(vt[v].x, vt[v].y, vt[v].b);
      wait_fv();
      chk($sformatf("v%0d_xy", v), 40'({a_x, a_y}),
          40'({vt[v].x, vt[v].y}));
      chk($sformatf("v%0d_lv", v), 40'({a_clk, a_dclk}),
          40'(vt[v].lv));
      chk($sformatf("v%0d_dir_a", v), 40'({a_l, a_r, a_u, a_d}),
          40'(vt[v].dirs));
      chk($sformatf("v%0d_dir_b", v), 40'({b_l, b_r, b_u, b_d}),
          40'(vt[v].dirs));
    end

    fbits = mk(10'd100, 10'd512, 8'h00);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (!a_ss && rcnt >= 17 && rcnt < 24) begin
        ok = 1'b1;
        break;
      end
    end
    chk("byte2_reached", 40'(ok), 40'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ss", 40'(a_ss), 40'd1);
    chk("mid_rst_sclk", 40'(a_sclk), 40'd0);
    chk("mid_rst_pos", 40'({a_x, a_y}), 40'({10'd512, 10'd512}));
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    moved = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (a_fv) begin
        ok = 1'b1;
        break;
      end
      if (a_x !== 10'd512) moved = 1'b1;
    end
    chk("post_rst_fv", 40'(ok), 40'd1);
    chk("post_rst_hold", 40'(moved), 40'd0);
    chk("post_rst_x", 40'(a_x), 40'd100);
    chk("post_rst_left", 40'({a_l, a_r, a_u, a_d}), 40'b1000);

    @(posedge clk);
    #1;
    chk("stray_pulses", 40'(stray), 40'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
